// File: rtl/rca32_pkg.sv
// Shared constants for the 32-bit ripple-carry adder/subtractor.
package rca32_pkg;
   localparam int   WIDTH    = 32;
   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/full_adder.sv
// Combinational 1-bit full-adder cell used as one link of the ripple chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/rca_32bit.sv
// Registered 32-bit ripple-carry adder with optional subtract (macro RCA32_SUB_EN).
// Without RCA32_SUB_EN the block always adds and subtract_mode is ignored.
module rca_32bit
   import rca32_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             carry_in,
   input  logic             subtract_mode,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);
   logic [WIDTH-1:0] b_eff_p0;
   logic [WIDTH-1:0] sum_p0;
   logic [WIDTH:0]   c_p0;
   logic             carry_p0;
   logic             ovf_p0;

`ifdef RCA32_SUB_EN
   logic sub;
   assign sub         = (subtract_mode == MODE_SUB);
   assign b_eff_p0    = operand_b ^ {WIDTH{sub}};
   assign c_p0[0]     = carry_in ^ sub;
   // Raw chain carry is inverted in subtract mode so it reads as borrow-out.
   assign carry_p0    = c_p0[WIDTH] ^ sub;
`else
   logic unused_mode;
   assign unused_mode = subtract_mode;
   assign b_eff_p0    = operand_b;
   assign c_p0[0]     = carry_in;
   assign carry_p0    = c_p0[WIDTH];
`endif

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_chain
         full_adder u_fa (
            .a    (operand_a[i]),
            .b    (b_eff_p0[i]),
            .cin  (c_p0[i]),
            .sum  (sum_p0[i]),
            .cout (c_p0[i+1])
         );
      end
   endgenerate

   assign ovf_p0 = c_p0[WIDTH] ^ c_p0[WIDTH-1];

   // Stage p0 -> output register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         result    <= sum_p0;
         carry_out <= carry_p0;
         overflow  <= ovf_p0;
      end
   end
endmodule

// File: tb/tb_rca_32bit.sv
// Self-checking bench for rca_32bit: directed table, reset sequence and random throughput.
module tb_rca_32bit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] operand_a, operand_b;
   logic        carry_in, subtract_mode;
   logic [31:0] result;
   logic        carry_out, overflow;

   int checks = 0;
   int passed = 0;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] res;
      logic        co;
      logic        ov;
   } vec_t;

   vec_t vecs[$];

   rca_32bit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .carry_in      (carry_in),
      .subtract_mode (subtract_mode),
      .result        (result),
      .carry_out     (carry_out),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic, unsigned for carry/borrow, signed for overflow.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub,
                                 output logic [31:0] res, output logic co,
                                 output logic ov);
      longint ua, ub, sa, sb, ur, sr;
      logic   do_sub;
`ifdef RCA32_SUB_EN
      do_sub = sub;
`else
      do_sub = 1'b0;
`endif
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (do_sub) begin
         ur = ua - ub - longint'(cin);
         sr = sa - sb - longint'(cin);
         co = (ur < 0);
      end else begin
         ur = ua + ub + longint'(cin);
         sr = sa + sb + longint'(cin);
         co = (ur >= 64'sd4294967296);
      end
      res = ur[31:0];
      ov  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
   endfunction

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %08h expected %08h", name, got, exp);
   endtask

   task automatic check1(input string name, input logic got, input logic exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %b expected %b", name, got, exp);
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub);
      operand_a     = a;
      operand_b     = b;
      carry_in      = cin;
      subtract_mode = sub;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add_vec(input string n, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input logic [31:0] r,
                          input logic co, input logic ov);
      vec_t v;
      v.name = n; v.a = a; v.b = b; v.cin = cin; v.sub = sub;
      v.res = r; v.co = co; v.ov = ov;
      vecs.push_back(v);
   endtask

   initial begin
      logic [31:0] er;
      logic        eco, eov;
      logic [31:0] pa, pb;
      logic        pc, ps;

      add_vec("add_wrap",    32'hFFFFFFFF, 32'h1,        1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
      add_vec("add_sovf",    32'h7FFFFFFF, 32'h1,        1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
      add_vec("add_negneg",  32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1);
      add_vec("add_cin",     32'h0,        32'h0,        1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0);
      add_vec("add_alt",     32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
      add_vec("add_ones",    32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0);
`ifdef RCA32_SUB_EN
      add_vec("sub_5m3",     32'd5,        32'd3,        1'b0, 1'b1, 32'h00000002, 1'b0, 1'b0);
      add_vec("sub_3m5",     32'd3,        32'd5,        1'b0, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0);
      add_vec("sub_0m0",     32'd0,        32'd0,        1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0);
      add_vec("sub_bin",     32'd5,        32'd3,        1'b1, 1'b1, 32'h00000001, 1'b0, 1'b0);
      add_vec("sub_minm1",   32'h80000000, 32'h1,        1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1);
      add_vec("sub_maxmmin", 32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1);
      // Positive minus negative giving a negative-looking result is a signed overflow.
      add_vec("sub_mixed",   32'h12345678, 32'h87654321, 1'b0, 1'b1, 32'h8ACF1357, 1'b1, 1'b1);
`else
      add_vec("ign_sub",     32'd5,        32'd3,        1'b0, 1'b1, 32'h00000008, 1'b0, 1'b0);
      add_vec("ign_sub_cin", 32'hFFFFFFFF, 32'h0,        1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0);
`endif

      // Reset held for two edges with live operands; reset wins over the operation.
      rst_n = 1'b0;
      drive(32'hDEADBEEF, 32'hCAFEF00D, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
         tick();
         check32("rst_result", result, 32'h0);
         check1("rst_cout", carry_out, 1'b0);
         check1("rst_ovf", overflow, 1'b0);
         drive(32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0);
      end
      rst_n = 1'b1;
      drive(32'h1000, 32'h2000, 1'b0, 1'b0);
      tick();
      check32("post_rst_result", result, 32'h00003000);
      check1("post_rst_cout", carry_out, 1'b0);
      check1("post_rst_ovf", overflow, 1'b0);

      // Directed table, also cross-checked against the model.
      foreach (vecs[i]) begin
         drive(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
         tick();
         check32({vecs[i].name, "_res"}, result, vecs[i].res);
         check1({vecs[i].name, "_co"}, carry_out, vecs[i].co);
         check1({vecs[i].name, "_ov"}, overflow, vecs[i].ov);
         model(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, er, eco, eov);
         check32({vecs[i].name, "_model"}, result, er);
      end

      // Outputs hold between edges once inputs stop changing.
      drive(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
      tick();
      #3;
      check32("hold_result", result, 32'h00010000);

      // Back-to-back random operations, one per cycle.
      for (int n = 0; n < 100; n++) begin
         pa = $urandom; pb = $urandom;
         pc = 1'($urandom_range(0, 1));
         ps = 1'($urandom_range(0, 1));
         if (n % 10 == 0) pb = pa;
         drive(pa, pb, pc, ps);
         tick();
         model(pa, pb, pc, ps, er, eco, eov);
         check32("rand_res", result, er);
         check1("rand_co", carry_out, eco);
         check1("rand_ov", overflow, eov);
      end

      // Reset in the middle of traffic clears the outputs at the same edge.
      rst_n = 1'b0;
      drive(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0);
      tick();
      check32("midrst_result", result, 32'h0);
      check1("midrst_ovf", overflow, 1'b0);
      rst_n = 1'b1;
      tick();
      check32("after_midrst_result", result, 32'h80000000);
      check1("after_midrst_ovf", overflow, 1'b1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
